imem_dmem_arbiter: RTL and testbench

- Shares the single synchronous 32-bit word memory between two requesters of the RISC-V core: the instruction-fetch port (IF) and the load/store data port (D).
- Each cycle it chooses at most one request, drives the memory strobes, and routes the 1-cycle-latency read data back to the owner.
- Data accesses normally win; a starvation counter guarantees forward progress for IF.
- Sits between the core's fetch and LSU stages and the memory instance.

---
 rtl/core_mem_pkg.sv | 17 +
 rtl/arb2_starve.sv | 62 ++++++
 rtl/imem_dmem_arbiter.sv | 98 +++++++++
 tb/tb_imem_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core's instruction/data memory path.
package core_mem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  typedef enum logic {
    LAST_IF = 1'b0,
    LAST_D  = 1'b1
  } last_owner_e;

endpackage

// File: rtl/arb2_starve.sv
// Two-way arbiter: fixed D priority with an IF starvation guard, or round-robin.
module arb2_starve
  import core_mem_pkg::*;
#(
  parameter int MAX_WAIT    = 4,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  last_owner_e      last_owner_q, last_owner_d;

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (req_if && req_d) begin
      if (ROUND_ROBIN) begin
        gnt_if = (last_owner_q == LAST_D);
      end else begin
        gnt_if = (wait_cnt_q == WAIT_LIMIT);
      end
      gnt_d = !gnt_if;
    end else begin
      gnt_if = req_if;
      gnt_d  = req_d;
    end

    // Count only consecutive denied cycles; a dropped request restarts the count.
    wait_cnt_d = '0;
    if (req_if && !gnt_if) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + CNT_ONE;
    end

    last_owner_d = last_owner_q;
    if (gnt_if) begin
      last_owner_d = LAST_IF;
    end else if (gnt_d) begin
      last_owner_d = LAST_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      last_owner_q <= LAST_IF;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous word memory between instruction fetch and the LSU,
// steering strobes to the winner and routing 1-cycle read data back.
module imem_dmem_arbiter
  import core_mem_pkg::*;
#(
  parameter int MAX_WAIT    = 4,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read_ready,
  output logic              mem_ok_read,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_write_ready,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [STRB_W-1:0] mem_write_byte,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic              req_if, req_d, gnt_if, gnt_d;
  logic              d_read_gnt, d_write_gnt;
  logic [1:0]        resp_owner_q, resp_owner_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Requests are masked while reset is held so nothing is granted or strobed.
  assign req_if = if_req & rst_n;
  assign req_d  = d_req & rst_n;

  arb2_starve #(
    .MAX_WAIT    (MAX_WAIT),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (req_if),
    .req_d  (req_d),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign d_read_gnt  = gnt_d & ~d_we;
  assign d_write_gnt = gnt_d & d_we;
  assign mem_ok_read = mem_read_ready;

  always_comb begin
    if_gnt            = gnt_if;
    d_gnt             = gnt_d;
    mem_read_ready    = gnt_if | d_read_gnt;
    mem_read_address  = gnt_if ? if_addr : (d_read_gnt ? d_addr : '0);
    mem_write_ready   = d_write_gnt;
    mem_write_address = d_write_gnt ? d_addr  : '0;
    mem_write_data    = d_write_gnt ? d_wdata : '0;
    mem_write_byte    = d_write_gnt ? d_wstrb : '0;

    resp_owner_d = OWN_NONE;
    if (gnt_if) begin
      resp_owner_d = OWN_IF;
    end else if (d_read_gnt) begin
      resp_owner_d = OWN_D;
    end

    // Response routing depends only on last cycle's owner, not on this cycle's grant.
    if_rvalid  = (resp_owner_q == OWN_IF);
    d_rvalid   = (resp_owner_q == OWN_D);
    if_rdata_d = if_rvalid ? mem_read_data : if_rdata_q;
    d_rdata_d  = d_rvalid  ? mem_read_data : d_rdata_q;
    if_rdata   = if_rdata_d;
    d_rdata    = d_rdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner_q <= OWN_NONE;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: instance 0 uses fixed priority, instance 1 round-robin,
// both with MAX_WAIT=4, each attached to its own behavioural memory.
module tb_imem_dmem_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  logic        o_if_gnt [2], o_if_rvalid [2], o_d_gnt [2], o_d_rvalid [2];
  logic [31:0] o_if_rdata [2], o_d_rdata [2];
  logic        m_rd [2], m_ok [2], m_wr [2];
  logic [29:0] m_raddr [2], m_waddr [2];
  logic [31:0] m_wdata [2], m_rdata [2];
  logic [3:0]  m_wbyte [2];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.MAX_WAIT(MAXW), .ROUND_ROBIN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]),
    .if_rvalid(o_if_rvalid[0]), .if_rdata(o_if_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(o_d_gnt[0]), .d_rvalid(o_d_rvalid[0]), .d_rdata(o_d_rdata[0]),
    .mem_read_ready(m_rd[0]), .mem_ok_read(m_ok[0]), .mem_read_address(m_raddr[0]),
    .mem_write_ready(m_wr[0]), .mem_write_address(m_waddr[0]),
    .mem_write_data(m_wdata[0]), .mem_write_byte(m_wbyte[0]),
    .mem_read_data(m_rdata[0])
  );

  imem_dmem_arbiter #(.MAX_WAIT(MAXW), .ROUND_ROBIN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]),
    .if_rvalid(o_if_rvalid[1]), .if_rdata(o_if_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(o_d_gnt[1]), .d_rvalid(o_d_rvalid[1]), .d_rdata(o_d_rdata[1]),
    .mem_read_ready(m_rd[1]), .mem_ok_read(m_ok[1]), .mem_read_address(m_raddr[1]),
    .mem_write_ready(m_wr[1]), .mem_write_address(m_waddr[1]),
    .mem_write_data(m_wdata[1]), .mem_write_byte(m_wbyte[1]),
    .mem_read_data(m_rdata[1])
  );

  // Power-up contents of every word; two fixed words serve the directed checks.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'h0050_0093;
    if (a == 8'h20) return 32'h1122_3344;
    return {a, 8'hA5, ~a, a ^ 8'h3C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous memory attached to each instance, one-cycle read latency.
  logic [31:0] mem [2][256];
  bit   [255:0] written [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_rd[k])
        m_rdata[k] <= written[k][m_raddr[k][7:0]] ? mem[k][m_raddr[k][7:0]]
                                                  : init_val(m_raddr[k][7:0]);
      if (m_wr[k]) begin
        mem[k][m_waddr[k][7:0]] <= merge(written[k][m_waddr[k][7:0]] ? mem[k][m_waddr[k][7:0]]
                                                                     : init_val(m_waddr[k][7:0]),
                                         m_wdata[k], m_wbyte[k]);
        written[k][m_waddr[k][7:0]] <= 1'b1;
      end
    end
  end

  // Reference model state, per instance.
  int          wcnt [2], last_d [2], pend [2];
  logic [31:0] pend_data [2], hold_if [2], hold_d [2];
  logic [31:0] ref_mem [2][256];

  typedef struct {
    logic       if_req;
    logic       d_req;
    logic [1:0] exp0;
    logic [1:0] exp1;
  } vec_t;

  vec_t tbl [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [29:0] ia, input logic dr,
                               input logic dw, input logic [29:0] da,
                               input logic [31:0] wd, input logic [3:0] ws);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = wd;
    d_wstrb = ws;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic modelResetState();
    for (int k = 0; k < 2; k++) begin
      wcnt[k] = 0; last_d[k] = 0; pend[k] = 0;
      pend_data[k] = '0; hold_if[k] = '0; hold_d[k] = '0;
    end
  endtask

  // Predicts this cycle's outputs from the arbitration rules, then advances.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      bit          gi, gd, rd, wr;
      logic [7:0]  a;
      logic [29:0] ra;
      if (pend[k] == 1) hold_if[k] = pend_data[k];
      if (pend[k] == 2) hold_d[k]  = pend_data[k];
      checkOutput($sformatf("i%0d.if_rvalid", k), 32'(o_if_rvalid[k]), 32'(pend[k] == 1));
      checkOutput($sformatf("i%0d.d_rvalid", k), 32'(o_d_rvalid[k]), 32'(pend[k] == 2));
      checkOutput($sformatf("i%0d.if_rdata", k), o_if_rdata[k], hold_if[k]);
      checkOutput($sformatf("i%0d.d_rdata", k), o_d_rdata[k], hold_d[k]);

      if (if_req && d_req) begin
        gi = (k == 1) ? (last_d[k] == 1) : (wcnt[k] == MAXW);
        gd = !gi;
      end else begin
        gi = if_req;
        gd = d_req;
      end
      rd = gi || (gd && !d_we);
      wr = gd && d_we;
      ra = gi ? if_addr : ((gd && !d_we) ? d_addr : 30'd0);
      checkOutput($sformatf("i%0d.if_gnt", k), 32'(o_if_gnt[k]), 32'(gi));
      checkOutput($sformatf("i%0d.d_gnt", k), 32'(o_d_gnt[k]), 32'(gd));
      checkOutput($sformatf("i%0d.rd_strobe", k), 32'({m_rd[k], m_ok[k]}), 32'({rd, rd}));
      checkOutput($sformatf("i%0d.rd_addr", k), 32'(m_raddr[k]), 32'(ra));
      checkOutput($sformatf("i%0d.wr_strobe", k), 32'(m_wr[k]), 32'(wr));
      checkOutput($sformatf("i%0d.wr_addr", k), 32'(m_waddr[k]), wr ? 32'(d_addr) : 32'd0);
      checkOutput($sformatf("i%0d.wr_data", k), m_wdata[k], wr ? d_wdata : 32'd0);
      checkOutput($sformatf("i%0d.wr_byte", k), 32'(m_wbyte[k]), wr ? 32'(d_wstrb) : 32'd0);

      a = ra[7:0];
      pend[k] = gi ? 1 : ((gd && !d_we) ? 2 : 0);
      if (rd) pend_data[k] = ref_mem[k][a];
      if (wr) ref_mem[k][d_addr[7:0]] = merge(ref_mem[k][d_addr[7:0]], d_wdata, d_wstrb);
      if (if_req && !gi) wcnt[k] = (wcnt[k] < MAXW) ? wcnt[k] + 1 : MAXW;
      else wcnt[k] = 0;
      if (gi) last_d[k] = 0;
      else if (gd) last_d[k] = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] prev [2];
    logic [1:0] got;

    tbl = '{
      '{1'b1, 1'b1, 2'b01, 2'b01}, '{1'b1, 1'b1, 2'b01, 2'b10},
      '{1'b1, 1'b1, 2'b01, 2'b01}, '{1'b1, 1'b1, 2'b01, 2'b10},
      '{1'b1, 1'b1, 2'b10, 2'b01}, '{1'b1, 1'b1, 2'b01, 2'b10},
      '{1'b1, 1'b1, 2'b01, 2'b01}, '{1'b1, 1'b1, 2'b01, 2'b10},
      '{1'b1, 1'b1, 2'b01, 2'b01}, '{1'b1, 1'b1, 2'b10, 2'b10},
      '{1'b0, 1'b0, 2'b00, 2'b00}
    };

    // Reset held with both requesters active: everything must stay quiet.
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 30'h3; d_addr = 30'h3; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
    #7;
    checkOutput("reset.gnt", 32'({o_if_gnt[0], o_d_gnt[0]}), 32'd0);
    checkOutput("reset.rvalid", 32'({o_if_rvalid[0], o_d_rvalid[0]}), 32'd0);
    checkOutput("reset.strobes", 32'({m_rd[0], m_ok[0], m_wr[0]}), 32'd0);
    checkOutput("reset.rd_addr", 32'(m_raddr[0]), 32'd0);
    checkOutput("reset.wr_addr", 32'(m_waddr[0]), 32'd0);
    checkOutput("reset.wr_data", m_wdata[0], 32'd0);
    checkOutput("reset.wr_byte", 32'(m_wbyte[0]), 32'd0);
    checkOutput("reset.if_rdata", o_if_rdata[0], 32'd0);
    checkOutput("reset.d_rdata", o_d_rdata[0], 32'd0);
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single instruction fetch.
    applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    checkOutput("fetch.if_gnt", 32'(o_if_gnt[0]), 32'd1);
    checkOutput("fetch.rd_strobe", 32'(m_rd[0]), 32'd1);
    checkOutput("fetch.rd_addr", 32'(m_raddr[0]), 32'h10);
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    checkOutput("fetch.if_rvalid", 32'(o_if_rvalid[0]), 32'd1);
    checkOutput("fetch.if_rdata", o_if_rdata[0], 32'h0050_0093);
    checkOutput("fetch.d_rvalid", 32'(o_d_rvalid[0]), 32'd0);

    // Partial write then read-back of the same word.
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b1, 30'h20, 32'hDEAD_BEEF, 4'b0011);
    checkOutput("wr.d_gnt", 32'(o_d_gnt[0]), 32'd1);
    checkOutput("wr.strobes", 32'({m_rd[0], m_wr[0]}), 32'b01);
    checkOutput("wr.wr_addr", 32'(m_waddr[0]), 32'h20);
    checkOutput("wr.wr_data", m_wdata[0], 32'hDEAD_BEEF);
    checkOutput("wr.wr_byte", 32'(m_wbyte[0]), 32'b0011);
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b0, 30'h20, 32'h0, 4'h0);
    checkOutput("rd.d_gnt", 32'(o_d_gnt[0]), 32'd1);
    checkOutput("rd.d_rvalid_after_write", 32'(o_d_rvalid[0]), 32'd0);
    checkOutput("rd.strobes", 32'({m_rd[0], m_wr[0]}), 32'b10);
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    checkOutput("rd.d_rvalid", 32'(o_d_rvalid[0]), 32'd1);
    checkOutput("rd.d_rdata", o_d_rdata[0], 32'h1122_BEEF);
    checkOutput("rd.if_rdata_hold", o_if_rdata[0], 32'h0050_0093);

    // Zero byte-enable write is still granted.
    applyStimulus(1'b0, 30'h0, 1'b1, 1'b1, 30'h21, 32'hFFFF_FFFF, 4'b0000);
    checkOutput("wstrb0.d_gnt", 32'(o_d_gnt[0]), 32'd1);
    checkOutput("wstrb0.wr_strobe", 32'(m_wr[0]), 32'd1);
    checkOutput("wstrb0.wr_byte", 32'(m_wbyte[0]), 32'd0);

    // Sustained conflict: starvation guard vs. round-robin.
    doReset();
    prev[0] = 2'b00; prev[1] = 2'b00;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].if_req, 30'h5, tbl[i].d_req, 1'b0, 30'h6, 32'h0, 4'h0);
      for (int k = 0; k < 2; k++) begin
        got = {o_if_gnt[k], o_d_gnt[k]};
        checkOutput($sformatf("conflict%0d.i%0d.gnt", i, k), 32'(got),
                    32'((k == 0) ? tbl[i].exp0 : tbl[i].exp1));
        got = {o_if_rvalid[k], o_d_rvalid[k]};
        checkOutput($sformatf("conflict%0d.i%0d.rvalid", i, k), 32'(got), 32'(prev[k]));
        if (prev[k] == 2'b10)
          checkOutput($sformatf("conflict%0d.i%0d.if_rdata", i, k), o_if_rdata[k], init_val(8'h5));
        if (prev[k] == 2'b01)
          checkOutput($sformatf("conflict%0d.i%0d.d_rdata", i, k), o_d_rdata[k], init_val(8'h6));
        prev[k] = (k == 0) ? tbl[i].exp0 : tbl[i].exp1;
      end
    end

    // Model-checked phases; the model memory mirrors the earlier partial write.
    doReset();
    modelResetState();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) ref_mem[k][a] = init_val(8'(a));
      ref_mem[k][8'h20] = 32'h1122_BEEF;
    end

    for (int i = 1; i <= 8; i++) begin
      if (i % 2 == 1) applyStimulus(1'b1, 30'(i), 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      else            applyStimulus(1'b0, 30'h0, 1'b1, 1'b0, 30'(i), 32'h0, 4'h0);
      modelStep();
    end
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    modelStep();

    // Reset lands while a fetch response is pending.
    applyStimulus(1'b1, 30'h30, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    modelStep();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    if_req = 1'b0;
    #1;
    checkOutput("midreset.if_rvalid", 32'(o_if_rvalid[0]), 32'd0);
    checkOutput("midreset.if_rdata", o_if_rdata[0], 32'd0);
    checkOutput("midreset.strobes", 32'({m_rd[0], m_wr[0], o_if_gnt[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelResetState();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      modelStep();
    end
    applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    modelStep();
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    modelStep();

    // Random traffic including drops, zero-strobe writes and conflicts.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 30'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 30'($urandom),
                    $urandom, 4'($urandom));
      modelStep();
    end
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    modelStep();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
